yuyv_splitter: RTL and testbench



---
 rtl/yuyv_splitter_pkg.sv | 25 ++
 rtl/yuyv_splitter.sv | 159 +++++++++++++++
 tb/tb_yuyv_splitter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/yuyv_splitter_pkg.sv
// Shared encodings for the YUYV splitter: frame state, byte phase and counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package yuyv_splitter_pkg;

    // Frame state: waiting for a start-of-frame byte, or inside a frame.
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // Position of the next byte within the repeating Y0 U Y1 V group.
    typedef enum logic [1:0] {
        P_Y0 = 2'd0,
        P_U  = 2'd1,
        P_Y1 = 2'd2,
        P_V  = 2'd3
    } phase_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/yuyv_splitter.sv
// Splits a packed YUYV 4:2:2 byte stream into Y, U and V FIFO write streams and tracks frame position.
// Latency: a byte accepted in cycle N is written (data + strobe) in cycle N+1; frame_done/sync_err align with that write.
// Backpressure: in_ready drops combinationally while any FIFO reports almost_full inside a frame; always ready in IDLE.
module yuyv_splitter
    import yuyv_splitter_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_sof,
    output logic                  in_ready,
    input  logic                  y_full,
    input  logic                  u_full,
    input  logic                  v_full,
    output logic [DATA_WIDTH-1:0] y_data,
    output logic [DATA_WIDTH-1:0] u_data,
    output logic [DATA_WIDTH-1:0] v_data,
    output logic                  y_write,
    output logic                  u_write,
    output logic                  v_write,
    output logic                  frame_done,
    output logic                  sync_err
);

    localparam int COL_W = cnt_width(IMG_WIDTH / 2);
    localparam int ROW_W = cnt_width(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH / 2 - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    state_e                state_q, state_d;
    phase_e                phase_q, phase_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [DATA_WIDTH-1:0] y_data_q, y_data_d;
    logic [DATA_WIDTH-1:0] u_data_q, u_data_d;
    logic [DATA_WIDTH-1:0] v_data_q, v_data_d;
    logic                  y_write_q, y_write_d;
    logic                  u_write_q, u_write_d;
    logic                  v_write_q, v_write_d;
    logic                  frame_done_q, frame_done_d;
    logic                  sync_err_q, sync_err_d;
    logic                  accept;

    // Only one write is ever in flight, so almost_full alone is enough to gate the source.
    assign in_ready = (state_q == IDLE) | ~(y_full | u_full | v_full);
    assign accept   = in_valid & in_ready;

    // Next-state, counter and output-register computation; everything holds unless a byte is accepted.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        col_d        = col_q;
        row_d        = row_q;
        y_data_d     = y_data_q;
        u_data_d     = u_data_q;
        v_data_d     = v_data_q;
        y_write_d    = 1'b0;
        u_write_d    = 1'b0;
        v_write_d    = 1'b0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;

        if (accept) begin
            if (in_sof) begin
                // A start-of-frame byte is always Y0 of a new frame, even if it lands on a V slot.
                sync_err_d = (state_q == ACTIVE);
                state_d    = ACTIVE;
                phase_d    = P_U;
                col_d      = '0;
                row_d      = '0;
                y_data_d   = in_data;
                y_write_d  = 1'b1;
            end else if (state_q == ACTIVE) begin
                unique case (phase_q)
                    P_Y0: begin
                        y_data_d  = in_data;
                        y_write_d = 1'b1;
                        phase_d   = P_U;
                    end
                    P_U: begin
                        u_data_d  = in_data;
                        u_write_d = 1'b1;
                        phase_d   = P_Y1;
                    end
                    P_Y1: begin
                        y_data_d  = in_data;
                        y_write_d = 1'b1;
                        phase_d   = P_V;
                    end
                    P_V: begin
                        v_data_d  = in_data;
                        v_write_d = 1'b1;
                        phase_d   = P_Y0;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (row_q == ROW_LAST) begin
                                row_d        = '0;
                                state_d      = IDLE;
                                frame_done_d = 1'b1;
                            end else begin
                                row_d = row_q + 1'b1;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                    default: phase_d = P_Y0;
                endcase
            end
            // Bytes accepted in IDLE without a start-of-frame are dropped.
        end
    end

    // State, counters and registered FIFO write ports; reset discards any partial frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            phase_q      <= P_Y0;
            col_q        <= '0;
            row_q        <= '0;
            y_data_q     <= '0;
            u_data_q     <= '0;
            v_data_q     <= '0;
            y_write_q    <= 1'b0;
            u_write_q    <= 1'b0;
            v_write_q    <= 1'b0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            col_q        <= col_d;
            row_q        <= row_d;
            y_data_q     <= y_data_d;
            u_data_q     <= u_data_d;
            v_data_q     <= v_data_d;
            y_write_q    <= y_write_d;
            u_write_q    <= u_write_d;
            v_write_q    <= v_write_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign y_data     = y_data_q;
    assign u_data     = u_data_q;
    assign v_data     = v_data_q;
    assign y_write    = y_write_q;
    assign u_write    = u_write_q;
    assign v_write    = v_write_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_yuyv_splitter.sv
// Testbench for yuyv_splitter on a 4x2 frame: directed scenarios plus randomized traffic.
// Expected output events come from a byte-position model of the YUYV frame layout.
// Each event carries the cycle it must appear in, so latency and pulse timing are checked too.
module tb_yuyv_splitter;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int FB = W * H * 2;   // bytes per frame

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic       in_ready;
    logic       y_full = 1'b0, u_full = 1'b0, v_full = 1'b0;
    logic [7:0] y_data, u_data, v_data;
    logic       y_write, u_write, v_write;
    logic       frame_done, sync_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    // Reference model: inside a frame or not, and byte offset within the frame.
    bit m_in_frame = 1'b0;
    int m_pos      = 0;

    yuyv_splitter #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
        .y_full(y_full), .u_full(u_full), .v_full(v_full),
        .y_data(y_data), .u_data(u_data), .v_data(v_data),
        .y_write(y_write), .u_write(u_write), .v_write(v_write),
        .frame_done(frame_done), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event word: cycle | kind (1=Y 2=U 3=V 4=frame_done 5=sync_err) | data.
    function automatic logic [31:0] ev(input int c, input int k, input logic [7:0] d);
        return {c[19:0], k[3:0], d};
    endfunction

    // Record what the DUT writes, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (y_write)    got_q.push_back(ev(cyc, 1, y_data));
            if (u_write)    got_q.push_back(ev(cyc, 2, u_data));
            if (v_write)    got_q.push_back(ev(cyc, 3, v_data));
            if (frame_done) got_q.push_back(ev(cyc, 4, 8'h00));
            if (sync_err)   got_q.push_back(ev(cyc, 5, 8'h00));
        end
    end

    // Frame layout: offsets 0,2 mod 4 are Y, 1 is U, 3 is V; the frame ends at offset FB-1.
    task automatic model_accept(input logic [7:0] d, input bit sof, input int c);
        if (sof) begin
            exp_q.push_back(ev(c, 1, d));
            if (m_in_frame) exp_q.push_back(ev(c, 5, 8'h00));
            m_in_frame = 1'b1;
            m_pos      = 1;
        end else if (m_in_frame) begin
            case (m_pos % 4)
                0, 2:    exp_q.push_back(ev(c, 1, d));
                1:       exp_q.push_back(ev(c, 2, d));
                default: exp_q.push_back(ev(c, 3, d));
            endcase
            if (m_pos == FB - 1) begin
                exp_q.push_back(ev(c, 4, 8'h00));
                m_in_frame = 1'b0;
                m_pos      = 0;
            end else begin
                m_pos = m_pos + 1;
            end
        end
    endtask

    // Present one byte until the model says it is accepted; optionally randomize full flags each cycle.
    task automatic send_byte(input logic [7:0] d, input bit sof, input bit rnd);
        bit acc;
        bit exp_rdy;
        acc      = 1'b0;
        in_data  = d;
        in_sof   = sof;
        in_valid = 1'b1;
        for (int t = 0; t < 64 && !acc; t++) begin
            if (rnd) begin
                y_full = ($urandom_range(0, 4) == 0);
                u_full = ($urandom_range(0, 4) == 0);
                v_full = ($urandom_range(0, 4) == 0);
            end
            @(negedge clk);
            exp_rdy = !m_in_frame || !(y_full || u_full || v_full);
            total++;
            if (in_ready !== exp_rdy) begin
                bad++;
                $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy);
            end
            if (exp_rdy) begin
                acc = 1'b1;
                model_accept(d, sof, cyc + 1);
            end
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout data=%h got=not_accepted exp=accepted", d);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] base);
        for (int i = 0; i < FB; i++) send_byte(base + 8'(i), i == 0, 1'b0);
    endtask

    task automatic test_reset;
        logic [29:0] got;
        reset = 1'b1;
        #2;
        got = {in_ready, y_write, u_write, v_write, frame_done, sync_err, y_data, u_data, v_data};
        total++;
        if (got !== {1'b1, 29'h0}) begin
            bad++;
            $display("FAIL reset_values got=%h exp=%h", got, {1'b1, 29'h0});
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_basic;
        int n_fd;
        exp_q.delete();
        got_q.delete();
        send_frame(8'h10);
        idle(3);
        n_fd = 0;
        foreach (got_q[i]) if (got_q[i][11:8] == 4'd4) n_fd++;
        total++;
        if (n_fd != 1) begin
            bad++;
            $display("FAIL basic_frame_done_count got=%0d exp=1", n_fd);
        end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL basic_ev[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stall;
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i), i == 0, 1'b0);
        u_full   = 1'b1;
        in_data  = 8'h16;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_ready[%0d] got=%b exp=0", k, in_ready);
            end
            @(posedge clk);
            #1;
        end
        u_full = 1'b0;
        for (int i = 6; i < FB; i++) send_byte(8'h10 + 8'(i), 1'b0, 1'b0);
        idle(3);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL stall_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL stall_ev[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_junk;
        exp_q.delete();
        got_q.delete();
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b0);
        send_frame(8'h10);
        idle(3);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL junk_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL junk_ev[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_resync;
        exp_q.delete();
        got_q.delete();
        // SOF on byte 5 restarts the frame; then SOF on the final V slot of the next frame.
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), i == 0, 1'b0);
        send_frame(8'h40);
        for (int i = 0; i < FB - 1; i++) send_byte(8'h60 + 8'(i), i == 0, 1'b0);
        send_frame(8'h80);
        idle(3);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL resync_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL resync_ev[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midframe;
        logic [29:0] got;
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 9; i++) send_byte(8'h30 + 8'(i), i == 0, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        m_in_frame = 1'b0;
        m_pos      = 0;
        #1;
        got = {in_ready, y_write, u_write, v_write, frame_done, sync_err, y_data, u_data, v_data};
        total++;
        if (got !== {1'b1, 29'h0}) begin
            bad++;
            $display("FAIL midreset_values got=%h exp=%h", got, {1'b1, 29'h0});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        send_frame(8'h50);
        idle(3);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL midreset_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL midreset_ev[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random;
        int r;
        exp_q.delete();
        got_q.delete();
        for (int it = 0; it < 600; it++) begin
            r = $urandom_range(0, 99);
            if (r < 10) idle($urandom_range(1, 3));
            else send_byte(8'($urandom), (it == 0) || (r < 14), 1'b1);
        end
        y_full = 1'b0;
        u_full = 1'b0;
        v_full = 1'b0;
        idle(3);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL random_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL random_ev[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_junk();
        test_resync();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
